// File: rtl/alu_exec_ctrl_pkg.sv
// Shared types and constants for the execute sequencer: FSM states, ALU opcodes,
// opcode-class encodings and flag bit positions.
package alu_exec_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

  // Source of the ALU B operand
  typedef enum logic [1:0] {B_REG, B_IMM8, B_IMM4} bsel_e;

  localparam logic [7:0] OP_SUB = 8'h09;
  localparam logic [7:0] OP_CMP = 8'h0B;

  localparam logic [3:0] HI_BASE  = 4'b0000;
  localparam logic [3:0] HI_ADDI  = 4'b0101;
  localparam logic [3:0] HI_ADDUI = 4'b0110;
  localparam logic [3:0] HI_ADDCI = 4'b0111;
  localparam logic [3:0] HI_SHIFT = 4'b1000;
  localparam logic [3:0] HI_SUBI  = 4'b1001;
  localparam logic [3:0] HI_CMPI  = 4'b1011;

  localparam int FZ = 4;
  localparam int FC = 3;
  localparam int FF = 2;
  localparam int FN = 1;
  localparam int FL = 0;
endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction request handshake plus the retire strobes seen by the issuer.
interface alu_exec_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] instr;
  logic        done;
  logic        illegal;

  modport master (output req_valid, instr, input req_ready, done, illegal);
  modport slave  (input req_valid, instr, output req_ready, done, illegal);
endinterface

// File: rtl/alu_exec_ctrl_decode.sv
// Combinational instruction decode: ALU opcode, B-operand source and
// writeback/flag-update permissions for one 16-bit instruction word.
module alu_op_decode
  import alu_exec_ctrl_pkg::*;
(
  input  logic [15:0] instr,
  output logic [7:0]  alu_opcode,
  output bsel_e       imm_sel,
  output logic        imm_sext,
  output logic        wb_allow,
  output logic        flag_wr,
  output logic        illegal
);
  logic [3:0] hi, ext;
  assign hi  = instr[15:12];
  assign ext = instr[7:4];

  always_comb begin
    alu_opcode = {hi, ext};
    imm_sel    = B_REG;
    imm_sext   = 1'b0;
    wb_allow   = 1'b0;
    flag_wr    = 1'b0;
    illegal    = 1'b0;
    case (hi)
      HI_BASE: begin
        // ext 0 is NOP: retires with neither writeback nor flag update
        if (ext != 4'h0) begin
          if (ext <= 4'h9) begin
            wb_allow = 1'b1;
            flag_wr  = 1'b1;
          end else if (ext == 4'hB || ext == 4'hF) begin
            flag_wr  = 1'b1;
          end else begin
            illegal  = 1'b1;
          end
        end
      end
      HI_ADDI, HI_ADDCI: begin
        imm_sel  = B_IMM8;
        imm_sext = 1'b1;
        wb_allow = 1'b1;
        flag_wr  = 1'b1;
      end
      HI_ADDUI: begin
        imm_sel  = B_IMM8;
        wb_allow = 1'b1;
        flag_wr  = 1'b1;
      end
      HI_SUBI: begin
        alu_opcode = OP_SUB;
        imm_sel    = B_IMM8;
        imm_sext   = 1'b1;
        wb_allow   = 1'b1;
        flag_wr    = 1'b1;
      end
      HI_CMPI: begin
        alu_opcode = OP_CMP;
        imm_sel    = B_IMM8;
        imm_sext   = 1'b1;
        flag_wr    = 1'b1;
      end
      HI_SHIFT: begin
        if (ext == 4'h0 || ext == 4'h1) begin
          imm_sel  = B_IMM4;
          wb_allow = 1'b1;
          flag_wr  = 1'b1;
        end else if (ext == 4'h4) begin
          wb_allow = 1'b1;
          flag_wr  = 1'b1;
        end else begin
          illegal  = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_exec_ctrl.sv
// Four-cycle execute sequencer (IDLE->READ->EXEC->WB) around an external
// combinational ALU; owns operand/result registers and the PSR flags.
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4,
  parameter int FLAG_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  alu_exec_ctrl_if.slave     req,
  output logic [RADDR_W-1:0] rf_ra_addr,
  output logic [RADDR_W-1:0] rf_rb_addr,
  input  logic [DATA_W-1:0]  rf_ra_data,
  input  logic [DATA_W-1:0]  rf_rb_data,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [7:0]         alu_opcode,
  output logic               alu_cin,
  input  logic [DATA_W-1:0]  alu_c,
  input  logic [FLAG_W-1:0]  alu_flags,
  output logic               wb_en,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic [FLAG_W-1:0]  psr_flags
);
  state_e              state, nxt;
  logic [15:0]         instr_q, ins_cur;
  logic [DATA_W-1:0]   opa, opb, res_q, b_mux;
  logic [FLAG_W-1:0]   flg_q;
  logic [7:0]          dec_opcode;
  bsel_e               dec_bsel;
  logic                dec_sext, dec_wb, dec_fw, dec_ill;

  alu_op_decode u_dec (
    .instr      (instr_q),
    .alu_opcode (dec_opcode),
    .imm_sel    (dec_bsel),
    .imm_sext   (dec_sext),
    .wb_allow   (dec_wb),
    .flag_wr    (dec_fw),
    .illegal    (dec_ill)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (req.req_valid) nxt = S_READ;
      S_READ:  nxt = S_EXEC;
      S_EXEC:  nxt = S_WB;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (dec_bsel)
      B_IMM8:  b_mux = dec_sext ? {{(DATA_W-8){instr_q[7]}}, instr_q[7:0]}
                                : {{(DATA_W-8){1'b0}}, instr_q[7:0]};
      B_IMM4:  b_mux = {{(DATA_W-4){1'b0}}, instr_q[3:0]};
      default: b_mux = rf_rb_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q   <= '0;
      opa       <= '0;
      opb       <= '0;
      res_q     <= '0;
      flg_q     <= '0;
      psr_flags <= '0;
    end else begin
      case (state)
        S_IDLE: if (req.req_valid) instr_q <= req.instr;
        S_READ: begin
          opa <= rf_ra_data;
          opb <= b_mux;
        end
        S_EXEC: begin
          res_q <= alu_c;
          flg_q <= alu_flags;
        end
        default: if (dec_fw && !dec_ill) psr_flags <= flg_q;
      endcase
    end
  end

  // Register addresses come straight off the bus in IDLE so the regfile
  // returns data during READ.
  assign ins_cur = (state == S_IDLE) ? req.instr : instr_q;

  always_comb begin
    req.req_ready = (state == S_IDLE);
    rf_ra_addr    = ins_cur[8 +: RADDR_W];
    rf_rb_addr    = ins_cur[0 +: RADDR_W];
    alu_a         = '0;
    alu_b         = '0;
    alu_opcode    = '0;
    alu_cin       = 1'b0;
    wb_en         = 1'b0;
    req.done      = 1'b0;
    req.illegal   = 1'b0;
    wb_addr       = instr_q[8 +: RADDR_W];
    wb_data       = res_q;
    if (state == S_EXEC) begin
      alu_a      = opa;
      alu_b      = opb;
      alu_opcode = dec_opcode;
      alu_cin    = psr_flags[FC];
    end
    // Strobes are masked by reset so an aborted instruction never retires
    if (state == S_WB && !reset) begin
      wb_en       = dec_wb && !dec_ill;
      req.done    = 1'b1;
      req.illegal = dec_ill;
    end
  end
endmodule
